// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum (IDLE, OWN) and the default requester count
// and maximum hold time used by arbiter_rr, rr_pick and arbiter_rr_if.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int N_DEFAULT        = 2;
    localparam int MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// Latency: n/a (wires only).
// Backpressure: none; grant is the only flow control seen by requesters.
//
// Signals:
//   request [N-1:0] requester i wants the shared resource
//   grant   [N-1:0] registered one-hot (or zero) grant
//   busy            high while any grant bit is high
// Modports: master = requester side, slave = arbiter side.
interface arbiter_rr_if
    import arb_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic [N-1:0] request;
    logic [N-1:0] grant;
    logic         busy;

    modport master (
        output request,
        input  grant,
        input  busy
    );

    modport slave (
        input  request,
        output grant,
        output busy
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   request_i [N-1:0]     candidate requests
//   ptr_i     [PTR_W-1:0] index with highest priority
//   pick_o    [N-1:0]     one-hot winner, zero when request_i is zero
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     request_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     pick_o
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_oh;

    // Rotate so that index ptr_i lands on bit 0; the wrap search becomes a
    // plain lowest-set-bit search.
    assign rot    = N'({request_i, request_i} >> ptr_i);

    // Two's-complement trick isolates the lowest set bit.
    assign rot_oh = rot & (-rot);

    // Rotate the one-hot back into the original index space.
    assign pick_o = N'(({rot_oh, rot_oh} << ptr_i) >> N);

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin arbiter with registered one-hot grant and optional timeout.
// Latency: request sampled at edge t is reflected in grant at edge t+1.
// Backpressure: owner keeps grant while requesting; releases move grant with no idle bubble.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   bus (slave)    request in, grant/busy out (see arbiter_rr_if)
// Build option: define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD
// cycles when another requester is waiting; without it the hold counter
// does not exist and the owner is never preempted.
module arbiter_rr
    import arb_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    arbiter_rr_if.slave bus
);

    localparam int PTR_W = $clog2(N);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("arbiter_rr: N must be in 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("arbiter_rr: MAX_HOLD must be in 1..255");
    end

    arb_state_e       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]     pick_req;
    logic [N-1:0]     pick;
    logic             owner_req;
    logic             others_pend;
    logic             take_new;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    logic [7:0] hcnt_q, hcnt_d;
`endif

    // While owning, the owner is masked out so the picker only sees the
    // others; since ptr is owner+1 the search naturally starts past it.
    assign pick_req    = (state_q == OWN) ? (bus.request & ~grant_q) : bus.request;
    assign others_pend = |pick_req;
    assign owner_req   = |(bus.request & grant_q);

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .request_i (pick_req),
        .ptr_i     (ptr_q),
        .pick_o    (pick)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        take_new = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hcnt_d   = hcnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (others_pend) begin
                    take_new = 1'b1;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    if (others_pend) begin
                        // Hand over directly; no all-zero cycle.
                        take_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hcnt_q == HOLD_MAX && others_pend) begin
                    take_new = 1'b1;
                end else if (hcnt_q != HOLD_MAX) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (take_new) begin
            state_d = OWN;
            grant_d = pick;
`ifdef ARB_TIMEOUT_EN
            hcnt_d  = 8'd1;
`endif
            for (int i = 0; i < N; i++) begin
                if (pick[i]) begin
                    ptr_d = PTR_W'((i + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            hcnt_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q == OWN);

endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 Parameter N, default 2: number of requesters; legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 4: maximum ownership cycles under contention; legal range 1..255.
REQ-003 Port clk  input  1: single clock; all state SHALL update on the rising edge only.
REQ-004 Port rst  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port request  input  N: request[i] high means requester i wants the resource.
REQ-006 Port grant  output  N: registered grant; one-hot or all zero.
REQ-007 Port busy  output  1: registered; high while any grant bit is high.

Function
REQ-008 FSM states SHALL be IDLE and OWN; busy SHALL equal 1 exactly when the state is OWN.
REQ-009 IDLE, request==0: state SHALL stay IDLE and grant SHALL stay 0.
REQ-010 IDLE, request!=0: on the next edge, grant SHALL become one-hot for the first set request bit at or after pointer ptr, searching in increasing index with wrap from N-1 to 0, and the state SHALL go to OWN.
REQ-011 Latency: a request sampled at edge t SHALL appear as grant at edge t+1, and never earlier.
REQ-012 OWN, owner's request still high, no preemption: grant SHALL hold unchanged.
REQ-013 OWN, owner's request sampled low, other requests pending: grant SHALL move directly to the next winner on that edge, with no all-zero bubble.
REQ-014 OWN, owner's request sampled low, no other request pending: grant SHALL become 0 and the state SHALL return to IDLE.
REQ-015 On every edge that issues a new grant to index i, ptr SHALL become (i+1) mod N.
REQ-016 Hold counter hcnt (8 bits) SHALL load 1 on a new grant and increment each cycle the grant is held, saturating at MAX_HOLD.
REQ-017 grant SHALL never have more than one bit set, including across reset and preemption edges.
REQ-018 Request bits that change while not owner SHALL NOT affect the current grant.

Reset
REQ-019 rst high at an edge SHALL force grant=0, busy=0, state=IDLE, ptr=0 and hcnt=0 on that edge, regardless of request.
REQ-020 Reset mid-ownership SHALL drop the grant on the same edge; the first grant after rst deasserts SHALL follow REQ-010 with ptr=0.
REQ-021 While rst is high, no grant SHALL be issued.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: in OWN, when hcnt==MAX_HOLD and at least one other request is pending, the grant SHALL move to the next winner per REQ-010 on the next edge, even if the owner still requests.
REQ-023 ARB_TIMEOUT_EN defined, no other request pending: the owner SHALL keep the grant and hcnt SHALL stay saturated.
REQ-024 ARB_TIMEOUT_EN undefined: there SHALL be no preemption, and hcnt SHALL be removed from the design.

Structure
REQ-025 Package arb_pkg SHALL hold the FSM state enum typedef (IDLE, OWN) and the default constants for N and MAX_HOLD.
REQ-026 Sub-module rr_pick SHALL implement the combinational rotating-priority picker, with inputs request and ptr and output a one-hot vector; arbiter_rr SHALL instantiate it once.

Verification (N=2, MAX_HOLD=4)
REQ-027 Reset, then request=01 driven at an edge -> grant=01 and busy=1 one edge later; grant still 01 two edges later.
REQ-028 From IDLE with ptr=0, request=11 -> grant=01; then request=10 -> grant=10 on the next edge, with no 00 cycle.
REQ-029 ARB_TIMEOUT_EN defined, request=11 held -> grant is 01 for 4 cycles, then 10 for 4 cycles, alternating.
REQ-030 ARB_TIMEOUT_EN undefined, request=11 held for 20 cycles -> grant stays 01 throughout.
REQ-031 rst pulsed while grant=10 -> grant=00 and busy=0 on that edge; request=11 after release -> grant=01.
REQ-032 request=00 for 10 cycles after reset -> grant=00 and busy=0 every cycle.
